// File: rtl/car_alarm_ctrl_if.sv
// Door/arm request bundle and alarm status outputs of the car alarm controller.
// Latency: none, plain signal bundle.
// Backpressure: none, all signals are level/pulse with no handshake.
// Optional: CAR_ALARM_SEG_EN adds the seg_out seven-segment bus.
interface car_alarm_ctrl_if;
    logic [4:0] door_open;
    logic [4:0] door_close;
    logic       arm;
    logic       disarm;
    logic [4:0] open_mask;
    logic       siren;
    logic       led;
    logic       arm_err;
    logic [2:0] state_o;
`ifdef CAR_ALARM_SEG_EN
    logic [6:0] seg_out;

    modport master (
        output door_open, door_close, arm, disarm,
        input  open_mask, siren, led, arm_err, state_o, seg_out
    );
    modport slave (
        input  door_open, door_close, arm, disarm,
        output open_mask, siren, led, arm_err, state_o, seg_out
    );
`else
    modport master (
        output door_open, door_close, arm, disarm,
        input  open_mask, siren, led, arm_err, state_o
    );
    modport slave (
        input  door_open, door_close, arm, disarm,
        output open_mask, siren, led, arm_err, state_o
    );
`endif
endinterface

// File: rtl/car_alarm_ctrl.sv
// Car alarm arm/disarm FSM with latched per-door open status, siren and blinking status LED.
// Latency: one clk edge from qualifying input to state/output change; registered Moore outputs.
// Backpressure: none, every input is sampled each rising edge. Optional: CAR_ALARM_SEG_EN adds seg_out.
module car_alarm_ctrl #(
    parameter int EXIT_DLY  = 8,
    parameter int ENTRY_DLY = 8,
    parameter int SIREN_LEN = 32,
    parameter int BLINK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    car_alarm_ctrl_if.slave  bus
);
    localparam int MAX_A   = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int MAX_DLY = (MAX_A > SIREN_LEN) ? MAX_A : SIREN_LEN;
    localparam int CNT_W   = ($clog2(MAX_DLY) < 1) ? 1 : $clog2(MAX_DLY);
    localparam int BLK_W   = ($clog2(BLINK_DIV) < 1) ? 1 : $clog2(BLINK_DIV);

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BLK_W-1:0]   r_blink, w_blink_nxt;
    logic               r_led, w_led_nxt;
    logic               r_siren;
    logic               r_arm_err, w_arm_err_nxt;
    logic [4:0]         r_open_mask;
    logic [4:0]         w_new_open;

    // Doors newly opened relative to the latched status; only these can trigger.
    assign w_new_open = bus.door_open & ~r_open_mask;

    // Door latch: open sets, close clears, open wins when both are asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_open_mask <= '0;
        else     r_open_mask <= (r_open_mask & ~bus.door_close) | bus.door_open;
    end

    // Next-state, delay counter, LED blink and arm-refusal decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_arm_err_nxt = 1'b0;
        w_led_nxt     = r_led;
        w_blink_nxt   = r_blink;

        if (bus.disarm) begin
            w_state_nxt = ST_DISARMED;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    if (bus.arm) begin
                        if (r_open_mask == 5'b0) w_state_nxt   = ST_EXIT;
                        else                     w_arm_err_nxt = 1'b1;
                    end
                end
                ST_EXIT: begin
                    if (r_cnt == CNT_W'(EXIT_DLY - 1)) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_new_open[4])         w_state_nxt = ST_ALARM;
                    else if (|w_new_open[3:0]) w_state_nxt = ST_ENTRY;
                end
                ST_ENTRY: begin
                    if (w_new_open[4] || r_cnt == CNT_W'(ENTRY_DLY - 1)) w_state_nxt = ST_ALARM;
                end
                ST_ALARM: begin
                    if (r_cnt == CNT_W'(SIREN_LEN - 1)) w_state_nxt = ST_ARMED;
                end
                default: w_state_nxt = ST_DISARMED;
            endcase
        end

        // Idle states hold the counter at zero; any state change restarts it.
        if (w_state_nxt != r_state || w_state_nxt == ST_DISARMED || w_state_nxt == ST_ARMED)
            w_cnt_nxt = '0;

        case (w_state_nxt)
            ST_EXIT, ST_ENTRY: begin
                if (w_state_nxt != r_state) begin
                    w_led_nxt   = 1'b1;
                    w_blink_nxt = '0;
                end else if (r_blink == BLK_W'(BLINK_DIV - 1)) begin
                    w_led_nxt   = ~r_led;
                    w_blink_nxt = '0;
                end else begin
                    w_blink_nxt = r_blink + BLK_W'(1);
                end
            end
            ST_ARMED, ST_ALARM: begin
                w_led_nxt   = 1'b1;
                w_blink_nxt = '0;
            end
            default: begin
                w_led_nxt   = 1'b0;
                w_blink_nxt = '0;
            end
        endcase
    end

    // State register and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_DISARMED;
            r_cnt     <= '0;
            r_blink   <= '0;
            r_led     <= 1'b0;
            r_siren   <= 1'b0;
            r_arm_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_blink   <= w_blink_nxt;
            r_led     <= w_led_nxt;
            r_siren   <= (w_state_nxt == ST_ALARM);
            r_arm_err <= w_arm_err_nxt;
        end
    end

    assign bus.open_mask = r_open_mask;
    assign bus.siren     = r_siren;
    assign bus.led       = r_led;
    assign bus.arm_err   = r_arm_err;
    assign bus.state_o   = r_state;

`ifdef CAR_ALARM_SEG_EN
    logic [6:0] r_seg;
    logic [6:0] w_seg_nxt;

    // Lowest-index open door selects the glyph (active-low segments).
    always_comb begin
        w_seg_nxt = 7'b1111111;
        if      (r_open_mask[0]) w_seg_nxt = 7'b0001110;
        else if (r_open_mask[1]) w_seg_nxt = 7'b0000011;
        else if (r_open_mask[2]) w_seg_nxt = 7'b0000110;
        else if (r_open_mask[3]) w_seg_nxt = 7'b1000110;
        else if (r_open_mask[4]) w_seg_nxt = 7'b0100001;
    end

    // Segment register trails the door latch by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_seg <= 7'b1111111;
        else     r_seg <= w_seg_nxt;
    end

    assign bus.seg_out = r_seg;
`endif
endmodule
